// File: rtl/rb_fill_controller.sv
// Row-buffer fill sequencer: prefill RBS-1 rows, then stream with window reads.
// Optional input stall is enabled by defining RB_CTRL_STALL_EN.
module rb_fill_controller #(
    parameter int RB_DEPTH   = 512,
    parameter int RBS        = 4,
    parameter int FRAME_ROWS = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
`ifdef RB_CTRL_STALL_EN
    input  logic                          stall,
`endif
    output logic                          en_e_mem_addr,
    output logic                          en_w_bram_addr,
    output logic                          en_r_bram_addr,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FRAME_ROWS)-1:0] row_cnt
);

    localparam int RW = $clog2(FRAME_ROWS);
    localparam int PW = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;

    localparam logic [RW-1:0] ROW_S = RW'(RBS - 1);
    localparam logic [RW-1:0] ROW_L = RW'(FRAME_ROWS - 1);
    localparam logic [PW-1:0] PIX_L = PW'(RB_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pix, pix_n;
    logic [RW-1:0] row_n;
    logic          en_e_n, en_w_n, en_r_n, busy_n, done_n;
    logic          hold;
    logic          last;

`ifdef RB_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // en_e_mem_addr doubles as "the current cycle made an issue", so the
    // counters always point at the issue of the current cycle.
    assign last = en_e_mem_addr && (pix == PIX_L) && (row_cnt == ROW_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pix            <= '0;
            row_cnt        <= '0;
            en_e_mem_addr  <= 1'b0;
            en_w_bram_addr <= 1'b0;
            en_r_bram_addr <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_n;
            pix            <= pix_n;
            row_cnt        <= row_n;
            en_e_mem_addr  <= en_e_n;
            en_w_bram_addr <= en_w_n;
            en_r_bram_addr <= en_r_n;
            busy           <= busy_n;
            done           <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        pix_n   = pix;
        row_n   = row_cnt;
        en_e_n  = 1'b0;
        en_r_n  = 1'b0;
        en_w_n  = en_e_mem_addr;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                pix_n  = '0;
                row_n  = '0;
                if (start) begin
                    state_n = PREFILL;
                    busy_n  = 1'b1;
                    en_e_n  = !hold;
                end
            end
            PREFILL, STREAM: begin
                if (last) begin
                    state_n = FLUSH;
                end else begin
                    if (en_e_mem_addr) begin
                        if (pix == PIX_L) begin
                            pix_n = '0;
                            row_n = row_cnt + RW'(1);
                        end else begin
                            pix_n = pix + PW'(1);
                        end
                    end
                    state_n = (row_n >= ROW_S) ? STREAM : PREFILL;
                    en_e_n  = !hold;
                    en_r_n  = !hold && (row_n >= ROW_S);
                end
            end
            FLUSH: begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                pix_n   = '0;
                row_n   = '0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rb_fill_controller.sv
// Directed bench for rb_fill_controller with RB_DEPTH=4, RBS=3, FRAME_ROWS=5.
module tb_rb_fill_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       en_e_mem_addr;
    logic       en_w_bram_addr;
    logic       en_r_bram_addr;
    logic       busy;
    logic       done;
    logic [2:0] row_cnt;

    int total = 0;
    int passed = 0;

    logic [63:0] st_m, rs_m, sl_m;
    logic [63:0] oe, ow, orr, od, ob;
    logic [2:0]  orc [0:63];

    always #5 clk = ~clk;

    rb_fill_controller #(
        .RB_DEPTH(4),
        .RBS(3),
        .FRAME_ROWS(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef RB_CTRL_STALL_EN
        .stall(stall),
`endif
        .en_e_mem_addr(en_e_mem_addr),
        .en_w_bram_addr(en_w_bram_addr),
        .en_r_bram_addr(en_r_bram_addr),
        .busy(busy),
        .done(done),
        .row_cnt(row_cnt)
    );

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Cycle n is the period after edge n-1; inputs set in cycle n hit edge n.
    task automatic capture(input int n_cyc);
        oe = '0; ow = '0; orr = '0; od = '0; ob = '0;
        start = st_m[0];
        rst = rs_m[0];
        stall = sl_m[0];
        for (int n = 1; n <= n_cyc; n++) begin
            @(posedge clk);
            #1;
            oe[n] = en_e_mem_addr;
            ow[n] = en_w_bram_addr;
            orr[n] = en_r_bram_addr;
            od[n] = done;
            ob[n] = busy;
            orc[n] = row_cnt;
            start = st_m[n];
            rst = rs_m[n];
            stall = sl_m[n];
        end
        start = 1'b0;
        rst = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (en_e_mem_addr !== 1'b0)
            $display("FAIL rst_en_e got=%b exp=0", en_e_mem_addr);
        else passed++;
        total++;
        if (en_w_bram_addr !== 1'b0)
            $display("FAIL rst_en_w got=%b exp=0", en_w_bram_addr);
        else passed++;
        total++;
        if (en_r_bram_addr !== 1'b0)
            $display("FAIL rst_en_r got=%b exp=0", en_r_bram_addr);
        else passed++;
        total++;
        if (busy !== 1'b0)
            $display("FAIL rst_busy got=%b exp=0", busy);
        else passed++;
        total++;
        if (done !== 1'b0)
            $display("FAIL rst_done got=%b exp=0", done);
        else passed++;
        total++;
        if (row_cnt !== 3'd0)
            $display("FAIL rst_row got=%0d exp=0", row_cnt);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic check_nominal(input string tag);
        total++;
        if (oe !== rng(1, 20))
            $display("FAIL %s_en_e got=%h exp=%h", tag, oe, rng(1, 20));
        else passed++;
        total++;
        if (orr !== rng(9, 20))
            $display("FAIL %s_en_r got=%h exp=%h", tag, orr, rng(9, 20));
        else passed++;
        total++;
        if (ow !== rng(2, 21))
            $display("FAIL %s_en_w got=%h exp=%h", tag, ow, rng(2, 21));
        else passed++;
        total++;
        if (od !== rng(22, 22))
            $display("FAIL %s_done got=%h exp=%h", tag, od, rng(22, 22));
        else passed++;
        total++;
        if (ob !== rng(1, 22))
            $display("FAIL %s_busy got=%h exp=%h", tag, ob, rng(1, 22));
        else passed++;
    endtask

    task automatic test_nominal();
        logic [2:0] exp_rc;
        do_reset();
        st_m = 64'h1; rs_m = '0; sl_m = '0;
        capture(26);
        check_nominal("nom");
        for (int n = 1; n <= 23; n += 4) begin
            exp_rc = (n >= 21) ? 3'd0 : 3'((n - 1) / 4);
            if (n == 21) n = 23;
            total++;
            if (orc[n] !== exp_rc)
                $display("FAIL nom_row_c%0d got=%0d exp=%0d", n, orc[n], exp_rc);
            else passed++;
        end
        total++;
        if ($countones(oe) !== 20)
            $display("FAIL nom_cnt_e got=%0d exp=20", $countones(oe));
        else passed++;
        total++;
        if ($countones(ow) !== 20)
            $display("FAIL nom_cnt_w got=%0d exp=20", $countones(ow));
        else passed++;
        total++;
        if ($countones(orr) !== 12)
            $display("FAIL nom_cnt_r got=%0d exp=12", $countones(orr));
        else passed++;
    endtask

    task automatic test_ignored_start();
        do_reset();
        st_m = rng(0, 0) | rng(3, 3) | rng(22, 22);
        rs_m = '0; sl_m = '0;
        capture(30);
        check_nominal("ign");
    endtask

    task automatic test_rst_midframe();
        logic [63:0] ee, ew, er, eb;
        do_reset();
        st_m = rng(0, 0) | rng(12, 12);
        rs_m = rng(10, 10);
        sl_m = '0;
        capture(18);
        ee = rng(1, 10) | rng(13, 18);
        ew = rng(2, 10) | rng(14, 18);
        er = rng(9, 10);
        eb = rng(1, 10) | rng(13, 18);
        total++;
        if (oe !== ee) $display("FAIL rmf_en_e got=%h exp=%h", oe, ee);
        else passed++;
        total++;
        if (ow !== ew) $display("FAIL rmf_en_w got=%h exp=%h", ow, ew);
        else passed++;
        total++;
        if (orr !== er) $display("FAIL rmf_en_r got=%h exp=%h", orr, er);
        else passed++;
        total++;
        if (ob !== eb) $display("FAIL rmf_busy got=%h exp=%h", ob, eb);
        else passed++;
        total++;
        if (od !== 64'h0) $display("FAIL rmf_done got=%h exp=0", od);
        else passed++;
        total++;
        if (orc[11] !== 3'd0)
            $display("FAIL rmf_row got=%0d exp=0", orc[11]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] ee, ed;
        do_reset();
        st_m = rng(0, 0) | rng(23, 23);
        rs_m = '0; sl_m = '0;
        capture(48);
        ee = rng(1, 20) | rng(24, 43);
        ed = rng(22, 22) | rng(45, 45);
        total++;
        if (oe !== ee) $display("FAIL b2b_en_e got=%h exp=%h", oe, ee);
        else passed++;
        total++;
        if (od !== ed) $display("FAIL b2b_done got=%h exp=%h", od, ed);
        else passed++;
        total++;
        if ($countones(orr) !== 24)
            $display("FAIL b2b_cnt_r got=%0d exp=24", $countones(orr));
        else passed++;
    endtask

`ifdef RB_CTRL_STALL_EN
    task automatic test_stall();
        logic [63:0] ee, ew, er;
        do_reset();
        st_m = 64'h1; rs_m = '0;
        sl_m = rng(5, 6);
        capture(28);
        ee = rng(1, 5) | rng(8, 22);
        ew = rng(2, 6) | rng(9, 23);
        er = rng(11, 22);
        total++;
        if (oe !== ee) $display("FAIL stl_en_e got=%h exp=%h", oe, ee);
        else passed++;
        total++;
        if (ow !== ew) $display("FAIL stl_en_w got=%h exp=%h", ow, ew);
        else passed++;
        total++;
        if (orr !== er) $display("FAIL stl_en_r got=%h exp=%h", orr, er);
        else passed++;
        total++;
        if (od !== rng(24, 24))
            $display("FAIL stl_done got=%h exp=%h", od, rng(24, 24));
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_ignored_start();
        test_rst_midframe();
        test_back_to_back();
`ifdef RB_CTRL_STALL_EN
        test_stall();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
